// File: rtl/cpu54_branch_pkg.sv
// Shared definitions for execute-stage branch resolution: op encodings, FSM states, widths.
package cpu54_branch_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BGEZ = 3'b011,
        BR_J    = 3'b100,
        BR_JAL  = 3'b101,
        BR_JR   = 3'b110,
        BR_JALR = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REDIR = 2'b01,
        FLUSH = 2'b10
    } br_state_e;

    function automatic logic is_link_op(input br_op_e op);
        return (op == BR_JAL) || (op == BR_JALR);
    endfunction

endpackage

// File: rtl/branch_target_gen.sv
// Combinational taken decision and target address for one branch/jump operation.
import cpu54_branch_pkg::*;

module branch_target_gen (
    input  br_op_e            op,
    input  logic              is_equal,
    input  logic [XLEN-1:0]   pc_plus4,
    input  logic [15:0]       imm16,
    input  logic [25:0]       jidx,
    input  logic [XLEN-1:0]   rs_val,
    output logic [XLEN-1:0]   target,
    output logic              taken
);

    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] j_target;

    // Word offset sign-extended and scaled to bytes; the add wraps modulo 2^32.
    assign br_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign j_target  = {pc_plus4[31:28], jidx, 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = br_target;
        case (op)
            BR_BEQ:          taken = is_equal;
            BR_BNE:          taken = !is_equal;
            BR_BGEZ:         taken = !rs_val[31];
            BR_J, BR_JAL: begin
                taken  = 1'b1;
                target = j_target;
            end
            BR_JR, BR_JALR: begin
                taken  = 1'b1;
                target = rs_val;
            end
            default:         taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_branch_resolve.sv
// Execute-stage branch resolution: registered redirect plus multi-cycle front-end flush.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
import cpu54_branch_pkg::*;

module ex_branch_resolve #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic [2:0]        br_op,
    input  logic              is_equal,
    input  logic [XLEN-1:0]   rs_val,
    input  logic [XLEN-1:0]   pc_plus4,
    input  logic [15:0]       imm16,
    input  logic [25:0]       jidx,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush_front,
    output logic              link_valid,
    output logic [XLEN-1:0]   link_addr,
    output logic              busy,
    output logic [XLEN-1:0]   br_total,
    output logic [XLEN-1:0]   br_taken
);

    br_op_e           op;
    logic             taken;
    logic [XLEN-1:0]  target;
    logic             accept;

    br_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  redirect_pc_q;
    logic             redirect_valid_q;
    logic             flush_q;
    logic             busy_q;

    assign op = br_op_e'(br_op);

    branch_target_gen u_target_gen (
        .op       (op),
        .is_equal (is_equal),
        .pc_plus4 (pc_plus4),
        .imm16    (imm16),
        .jidx     (jidx),
        .rs_val   (rs_val),
        .target   (target),
        .taken    (taken)
    );

    // Wrong-path instructions during REDIR/FLUSH are never accepted.
    assign accept     = ex_valid && !ex_stall && (state_q == IDLE);
    assign link_valid = accept && !rst && is_link_op(op);
    assign link_addr  = pc_plus4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            busy_q           <= 1'b0;
        end else if (!ex_stall) begin
            case (state_q)
                IDLE: begin
                    if (accept && taken) begin
                        state_q          <= REDIR;
                        cnt_q            <= CNT_W'(FLUSH_CYCLES - 1);
                        redirect_pc_q    <= target;
                        redirect_valid_q <= 1'b1;
                        flush_q          <= 1'b1;
                        busy_q           <= 1'b1;
                    end
                end
                REDIR: begin
                    redirect_valid_q <= 1'b0;
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= FLUSH;
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end
                end
                FLUSH: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q          <= IDLE;
                    cnt_q            <= '0;
                    redirect_valid_q <= 1'b0;
                    flush_q          <= 1'b0;
                    busy_q           <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_front    = flush_q;
    assign busy           = busy_q;

`ifdef BRANCH_STATS_EN
    logic [XLEN-1:0] br_total_q;
    logic [XLEN-1:0] br_taken_q;

    // Saturating event counters, updated only on accepted instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_total_q <= '0;
            br_taken_q <= '0;
        end else if (accept) begin
            if ((op != BR_NONE) && (br_total_q != '1))
                br_total_q <= br_total_q + XLEN'(1);
            if (taken && (br_taken_q != '1))
                br_taken_q <= br_taken_q + XLEN'(1);
        end
    end

    assign br_total = br_total_q;
    assign br_taken = br_taken_q;
`else
    assign br_total = '0;
    assign br_taken = '0;
`endif

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Directed self-checking bench for ex_branch_resolve with a redirect-target scoreboard.
module tb_ex_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_stall;
    logic [2:0]  br_op;
    logic        is_equal;
    logic [31:0] rs_val;
    logic [31:0] pc_plus4;
    logic [15:0] imm16;
    logic [25:0] jidx;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_front;
    logic        link_valid;
    logic [31:0] link_addr;
    logic        busy;
    logic [31:0] br_total;
    logic [31:0] br_taken;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_total = 0;
    logic [31:0] m_taken = 0;

    always #5 clk = ~clk;

    ex_branch_resolve #(.FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .br_op          (br_op),
        .is_equal       (is_equal),
        .rs_val         (rs_val),
        .pc_plus4       (pc_plus4),
        .imm16          (imm16),
        .jidx           (jidx),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_front    (flush_front),
        .link_valid     (link_valid),
        .link_addr      (link_addr),
        .busy           (busy),
        .br_total       (br_total),
        .br_taken       (br_taken)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef BRANCH_STATS_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    // Reference decision written from the ISA description.
    task automatic model(input logic [2:0] op, input logic eq, input logic [31:0] rs,
                         input logic [31:0] pc, input logic [15:0] imm, input logic [25:0] ji,
                         output logic tk, output logic [31:0] tgt);
        logic signed [31:0] off;
        off = 32'(signed'(imm)) * 4;
        tk  = 1'b0;
        tgt = pc + 32'(off);
        case (op)
            3'd1: tk = eq;
            3'd2: tk = !eq;
            3'd3: tk = ($signed(rs) >= 0);
            3'd4, 3'd5: begin tk = 1'b1; tgt = (pc & 32'hF000_0000) | ({6'd0, ji} << 2); end
            3'd6, 3'd7: begin tk = 1'b1; tgt = rs; end
            default: tk = 1'b0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0;
        br_op    = 3'd0;
    endtask

    // Present one instruction in EX while IDLE; checks the combinational link outputs.
    task automatic issue(input string tag, input logic [2:0] op, input logic eq, input logic [31:0] rs,
                         input logic [31:0] pc, input logic [15:0] imm, input logic [25:0] ji);
        logic tk;
        logic [31:0] tgt;
        ex_valid = 1'b1; br_op = op; is_equal = eq; rs_val = rs;
        pc_plus4 = pc; imm16 = imm; jidx = ji;
        model(op, eq, rs, pc, imm, ji, tk, tgt);
        if (tk) exp_q.push_back(tgt);
        if (op != 3'd0) m_total++;
        if (tk) m_taken++;
        #1;
        chk({tag, ".link_valid"}, 32'(link_valid), 32'((op == 3'd5) || (op == 3'd7)));
        chk({tag, ".link_addr"}, link_addr, pc);
        tick();
        idle_inputs();
    endtask

    task automatic chk_ctl(input string tag, input logic rv, input logic ff, input logic bz);
        chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
        chk({tag, ".flush_front"}, 32'(flush_front), 32'(ff));
        chk({tag, ".busy"}, 32'(busy), 32'(bz));
    endtask

    // Fetch consumes the redirect on a non-stalled valid cycle; compare against the scoreboard.
    always @(negedge clk) begin
        if (!rst && redirect_valid === 1'b1 && ex_stall === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("sb.unexpected_redirect", redirect_pc, 32'hDEAD_BEEF);
            end else begin
                chk("sb.redirect_pc", redirect_pc, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ex_stall = 1'b0; is_equal = 1'b0; rs_val = '0;
        pc_plus4 = '0; imm16 = '0; jidx = '0;
        ex_valid = 1'b1; br_op = 3'd5;
        #1;
        chk("rst.link_valid", 32'(link_valid), 32'd0);
        tick(); tick();
        chk_ctl("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.redirect_pc", redirect_pc, 32'h0);
        chk("rst.br_total", br_total, 32'h0);
        chk("rst.br_taken", br_taken, 32'h0);
        idle_inputs();
        rst = 1'b0;
        tick();

        // beq taken, backward offset
        issue("beq", 3'd1, 1'b1, 32'h0, 32'h0040_0010, 16'hFFFC, 26'h0);
        chk_ctl("beq.c1", 1'b1, 1'b1, 1'b1);
        chk("beq.pc", redirect_pc, 32'h0040_0000);
        tick(); chk_ctl("beq.c2", 1'b0, 1'b1, 1'b1);
        tick(); chk_ctl("beq.c3", 1'b0, 1'b0, 1'b0);

        // bne with equal operands: not taken
        issue("bne", 3'd2, 1'b1, 32'h0, 32'h0000_1000, 16'h0010, 26'h0);
        chk_ctl("bne", 1'b0, 1'b0, 1'b0);
        chk("bne.br_total", br_total, stat(32'd2));
        chk("bne.br_taken", br_taken, stat(32'd1));

        // jal: link same cycle, region-relative target
        issue("jal", 3'd5, 1'b0, 32'h0, 32'h8000_0004, 16'h0, 26'h0000123);
        chk_ctl("jal.c1", 1'b1, 1'b1, 1'b1);
        chk("jal.pc", redirect_pc, 32'h8000_048C);
        tick(); tick();
        chk_ctl("jal.end", 1'b0, 1'b0, 1'b0);

        // bgez negative then bgez wrap-around
        issue("bgez_neg", 3'd3, 1'b0, 32'hFFFF_FFFF, 32'h0000_2000, 16'h0004, 26'h0);
        chk_ctl("bgez_neg", 1'b0, 1'b0, 1'b0);
        issue("bgez_wrap", 3'd3, 1'b0, 32'h0, 32'hFFFF_FFFC, 16'h0001, 26'h0);
        chk_ctl("bgez_wrap.c1", 1'b1, 1'b1, 1'b1);
        chk("bgez_wrap.pc", redirect_pc, 32'h0000_0000);
        tick(); tick();

        // jr with a 3-cycle stall in REDIR, then a wrong-path jalr during FLUSH
        issue("jr", 3'd6, 1'b0, 32'h1234_5678, 32'h0000_3000, 16'h0, 26'h0);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_ctl("jr.stall", 1'b1, 1'b1, 1'b1);
            chk("jr.stall.pc", redirect_pc, 32'h1234_5678);
            tick();
        end
        ex_stall = 1'b0;
        chk_ctl("jr.unstall", 1'b1, 1'b1, 1'b1);
        tick();
        chk_ctl("jr.flush", 1'b0, 1'b1, 1'b1);
        ex_valid = 1'b1; br_op = 3'd7; rs_val = 32'hCAFE_0000; pc_plus4 = 32'h0000_4000;
        #1;
        chk("wrongpath.link_valid", 32'(link_valid), 32'd0);
        tick();
        idle_inputs();
        chk_ctl("wrongpath.after", 1'b0, 1'b0, 1'b0);
        tick();
        chk_ctl("wrongpath.idle", 1'b0, 1'b0, 1'b0);
        chk("stats.br_total", br_total, stat(m_total));
        chk("stats.br_taken", br_taken, stat(m_taken));

        // rst during FLUSH aborts, then a normal beq
        issue("beq_pre", 3'd1, 1'b1, 32'h0, 32'h0000_0100, 16'h0002, 26'h0);
        tick();
        chk_ctl("beq_pre.flush", 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_total = 0; m_taken = 0;
        chk_ctl("abort", 1'b0, 1'b0, 1'b0);
        chk("abort.pc", redirect_pc, 32'h0);
        chk("abort.br_total", br_total, 32'h0);
        issue("beq_post", 3'd1, 1'b1, 32'h0, 32'h0000_0200, 16'h0003, 26'h0);
        chk_ctl("beq_post.c1", 1'b1, 1'b1, 1'b1);
        chk("beq_post.pc", redirect_pc, 32'h0000_020C);
        tick(); tick();
        chk_ctl("beq_post.end", 1'b0, 1'b0, 1'b0);
        chk("post.br_taken", br_taken, stat(32'd1));

        chk("sb.drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
